// File: rtl/morse_tx_scheduler_if.sv
// Letter-request and status bundle between the key/switch logic and the Morse scheduler.
// master drives requests and abort; slave (the scheduler) returns queue status and the Morse line.
interface morse_tx_scheduler_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [2:0]        wr_data;
    logic              abort;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              busy;
    logic              z;
    logic              letter_done;

    modport master (
        output wr_en,
        output wr_data,
        output abort,
        input  full,
        input  empty,
        input  level,
        input  overflow,
        input  busy,
        input  z,
        input  letter_done
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  abort,
        output full,
        output empty,
        output level,
        output overflow,
        output busy,
        output z,
        output letter_done
    );
endinterface

// File: rtl/morse_tx_scheduler.sv
// Queues 3-bit letter codes (Q..X) and keys them back-to-back as Morse on z, one unit = TICK_DIV cycles.
// Latency: a write into an idle, empty queue raises z two cycles later.
// Backpressure: none; writes while full are dropped and flagged by a one-cycle overflow pulse.
module morse_tx_scheduler #(
    parameter int TICK_DIV   = 25000000,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 Resetn,
    morse_tx_scheduler_if.slave  bus
);

    localparam int                CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  TICK_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]   LEVEL_MAX = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        LGAP
    } state_t;

    // Left-aligned symbol pattern (1 = dash) plus symbol count.
    typedef struct packed {
        logic [3:0] pat;
        logic [2:0] len;
    } letter_t;

    function automatic letter_t lookup(input logic [2:0] code);
        letter_t e;
        case (code)
            3'd0:    e = '{pat: 4'b1101, len: 3'd4};
            3'd1:    e = '{pat: 4'b0100, len: 3'd3};
            3'd2:    e = '{pat: 4'b0000, len: 3'd3};
            3'd3:    e = '{pat: 4'b1000, len: 3'd1};
            3'd4:    e = '{pat: 4'b0010, len: 3'd3};
            3'd5:    e = '{pat: 4'b0001, len: 3'd4};
            3'd6:    e = '{pat: 4'b0110, len: 3'd3};
            default: e = '{pat: 4'b1001, len: 3'd4};
        endcase
        return e;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          pat_q, pat_d;
    logic [2:0]          len_q, len_d;
    logic [1:0]          rem_q, rem_d;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     level_q, level_d;
    logic                overflow_q;
    logic                z_q;
    logic                busy_q;
    logic                letter_done_q;
    logic [2:0]          mem_q [FIFO_DEPTH];

    logic                tick;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                load;
    letter_t             head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LEVEL_MAX);
    assign tick       = (cnt_q == TICK_MAX);
    assign head       = lookup(mem_q[rd_ptr_q]);
    assign push       = bus.wr_en && !fifo_full && !bus.abort;
    assign level_d    = level_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(load);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rem_d   = rem_q;
        load    = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            MARK: begin
                if (tick) begin
                    if (rem_q > 2'd1) begin
                        rem_d = rem_q - 2'd1;
                    end else if (len_q > 3'd1) begin
                        pat_d   = {pat_q[2:0], 1'b0};
                        len_d   = len_q - 3'd1;
                        rem_d   = 2'd1;
                        state_d = GAP;
                    end else begin
                        rem_d   = 2'd3;
                        state_d = LGAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    rem_d   = pat_q[3] ? 2'd3 : 2'd1;
                    state_d = MARK;
                end
            end
            LGAP: begin
                if (tick) begin
                    if (rem_q > 2'd1) begin
                        rem_d = rem_q - 2'd1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pat_d   = head.pat;
            len_d   = head.len;
            rem_d   = head.pat[3] ? 2'd3 : 2'd1;
            state_d = MARK;
        end

        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from next-state so they line up with state_q without input paths.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pat_q         <= '0;
            len_q         <= '0;
            rem_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            z_q           <= 1'b0;
            busy_q        <= 1'b0;
            letter_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            overflow_q    <= bus.wr_en && fifo_full && !bus.abort;
            z_q           <= (state_d == MARK);
            busy_q        <= (state_d != IDLE);
            letter_done_q <= (state_d == LGAP) && (cnt_d == TICK_MAX) && (rem_d == 2'd1);
            if (bus.abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                end
                if (load) begin
                    rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                end
                level_q <= level_d;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = busy_q;
    assign bus.z           = z_q;
    assign bus.letter_done = letter_done_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Bench for morse_tx_scheduler: letters queued on write, decoded from z and compared on letter_done.
module tb_morse_tx_scheduler;
    localparam int TICK_DIV   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    morse_tx_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    morse_tx_scheduler #(
        .TICK_DIV   (TICK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .bus      (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    logic [6:0] sb_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [6:0] exp_letter(input logic [2:0] c);
        case (c)
            3'd0:    return {4'b1101, 3'd4};
            3'd1:    return {4'b0100, 3'd3};
            3'd2:    return {4'b0000, 3'd3};
            3'd3:    return {4'b1000, 3'd1};
            3'd4:    return {4'b0010, 3'd3};
            3'd5:    return {4'b0001, 3'd4};
            3'd6:    return {4'b0110, 3'd3};
            default: return {4'b1001, 3'd4};
        endcase
    endfunction

    // Decode z into marks/gaps; compare each finished letter against the scoreboard.
    logic [3:0] mon_bits   = '0;
    int         mon_len    = 0;
    int         hi_run     = 0;
    int         lo_run     = 0;
    logic       prev_z     = 1'b0;
    logic       follow_chk = 1'b0;
    logic       follow_exp = 1'b0;

    always @(negedge clk) begin
        if (follow_chk && rst_n) begin
            check_eq("follow_z", bus.z, follow_exp);
            check_eq("follow_busy", bus.busy, follow_exp);
        end
        follow_chk = 1'b0;
        if (!rst_n || !bus.busy) begin
            mon_bits = '0;
            mon_len  = 0;
            hi_run   = 0;
            lo_run   = 0;
            prev_z   = 1'b0;
        end else begin
            if (bus.z) begin
                if (!prev_z && mon_len != 0) check_eq("intra_gap", lo_run, TICK_DIV);
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_z) begin
                    check_eq("mark_len", hi_run, (hi_run > 2 * TICK_DIV) ? 3 * TICK_DIV : TICK_DIV);
                    if (mon_len < 4) mon_bits[3 - mon_len] = (hi_run > 2 * TICK_DIV);
                    else check_eq("sym_count", mon_len, 3);
                    mon_len++;
                end
                hi_run = 0;
                lo_run++;
            end
            if (bus.letter_done) begin
                check_eq("letter_gap", lo_run, 3 * TICK_DIV);
                check_eq("sb_pending", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) check_eq("letter", {mon_bits, 3'(mon_len)}, sb_q.pop_front());
                done_cnt++;
                follow_chk = 1'b1;
                follow_exp = (sb_q.size() > 0);
                mon_bits   = '0;
                mon_len    = 0;
                hi_run     = 0;
                lo_run     = 0;
            end
            prev_z = bus.z;
        end
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic put_letter(input logic [2:0] code, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = code;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        if (accept) sb_q.push_back(exp_letter(code));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int base, input int n, input int budget);
        int c;
        c = 0;
        while ((done_cnt - base) < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] zv, zexp, dv, dexp;
        int          d0, busy_low, c;

        bus.wr_en   = 1'b0;
        bus.wr_data = 3'd0;
        bus.abort   = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_z", bus.z, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_level", bus.level, 0);
        check_eq("rst_overflow", bus.overflow, 0);
        check_eq("rst_letter_done", bus.letter_done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T: exact cycle waveform relative to the write cycle N.
        zv = '0; zexp = '0; dv = '0; dexp = '0;
        put_letter(3'd3, 1'b1);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            zv[k]   = bus.z;
            dv[k]   = bus.letter_done;
            zexp[k] = (k >= 2 && k <= 13);
            dexp[k] = (k == 25);
        end
        check_eq("t_z_wave", zv, zexp);
        check_eq("t_done_wave", dv, dexp);
        check_eq("t_busy_end", bus.busy, 0);
        idle(4);

        // S: single letter, one letter_done.
        d0 = done_cnt;
        put_letter(3'd2, 1'b1);
        wait_done(d0, 1, 300);
        idle(20);
        check_eq("s_done_cnt", done_cnt - d0, 1);

        // Q then R back to back: busy never drops between them.
        d0       = done_cnt;
        busy_low = 0;
        put_letter(3'd0, 1'b1);
        put_letter(3'd1, 1'b1);
        c = 0;
        while ((done_cnt - d0) < 2 && c < 600) begin
            @(negedge clk);
            #1;
            if (!bus.busy) busy_low++;
            c++;
        end
        check_eq("qr_done_cnt", done_cnt - d0, 2);
        check_eq("qr_busy_low", busy_low, 0);
        idle(20);

        // Fill while playing, one extra write overflows.
        d0 = done_cnt;
        put_letter(3'd7, 1'b1);
        for (int i = 0; i < 8; i++) put_letter(3'(i), 1'b1);
        check_eq("ovf_full", bus.full, 1);
        check_eq("ovf_level", bus.level, FIFO_DEPTH);
        check_eq("ovf_quiet", bus.overflow, 0);
        put_letter(3'd3, 1'b0);
        check_eq("ovf_pulse", bus.overflow, 1);
        check_eq("ovf_level_hold", bus.level, FIFO_DEPTH);
        idle(1);
        check_eq("ovf_pulse_end", bus.overflow, 0);
        wait_done(d0, 9, 1500);
        idle(40);
        check_eq("ovf_done_cnt", done_cnt - d0, 9);
        check_eq("ovf_drained", bus.empty, 1);
        check_eq("ovf_idle", bus.busy, 0);

        // Abort during W's first dash with three letters queued.
        put_letter(3'd6, 1'b1);
        put_letter(3'd7, 1'b1);
        put_letter(3'd0, 1'b1);
        put_letter(3'd5, 1'b1);
        idle(10);
        check_eq("abort_pre_z", bus.z, 1);
        check_eq("abort_pre_level", bus.level, 3);
        bus.abort   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 3'd2;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.wr_en = 1'b0;
        sb_q.delete();
        check_eq("abort_z", bus.z, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_empty", bus.empty, 1);
        check_eq("abort_level", bus.level, 0);
        check_eq("abort_no_ovf", bus.overflow, 0);
        d0 = done_cnt;
        idle(80);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_still_idle", bus.busy, 0);

        // Asynchronous reset in the middle of X's first dash.
        put_letter(3'd7, 1'b1);
        put_letter(3'd1, 1'b1);
        repeat (4) @(posedge clk);
        #3;
        check_eq("arst_pre_z", bus.z, 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_eq("arst_z", bus.z, 0);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_empty", bus.empty, 1);
        check_eq("arst_level", bus.level, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        put_letter(3'd4, 1'b1);
        wait_done(d0, 1, 300);
        idle(20);
        check_eq("u_done_cnt", done_cnt - d0, 1);
        check_eq("u_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/morse_tx_scheduler.md
Name: morse_tx_scheduler

Overview:
- Queues letter requests (3-bit letter codes Q..X) in an internal FIFO and plays them back-to-back on a single Morse output.
- Sequences standard timing: dot = 1 unit, dash = 3 units, intra-letter gap = 1 unit, inter-letter gap = 3 units.
- Sits between the switch/key input logic and the LED driver. Owns the unit-time prescaler and the letter pattern table.

Parameters:
- TICK_DIV, 25000000, clock cycles per Morse unit (0.5 s at 50 MHz); must be >= 2.
- FIFO_DEPTH, 8, letter queue entries; power of 2.
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  enqueue request, one letter per cycle.
- wr_data  in  3  letter code: 0=Q 1=R 2=S 3=T 4=U 5=V 6=W 7=X.
- abort  in  1  synchronous flush and stop.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  ADDR_W+1  FIFO occupancy.
- overflow  out  1  one-cycle pulse when a write is dropped.
- busy  out  1  high whenever state != IDLE.
- z  out  1  Morse output; 1 = mark.
- letter_done  out  1  one-cycle pulse at the end of each letter's trailing gap.

Behaviour:
- Reset (async, Resetn=0):
  - State goes to IDLE. FIFO pointers, level, prescaler, shift register and symbol counter all clear.
  - Outputs: z=0, busy=0, overflow=0, letter_done=0, empty=1, full=0.
- Pattern table (MSB first, 1=dash):
  - Q len4 1101; R len3 010; S len3 000; T len1 1.
  - U len3 001; V len4 0001; W len3 011; X len4 1001.
  - Stored as a 4-bit left-aligned pattern plus a 3-bit length.
- FIFO:
  - Registered write. Accepted when wr_en=1, full=0 and abort=0.
  - Write when full is dropped and overflow pulses, even if a pop occurs in the same cycle.
  - Write when empty is not visible to the FSM until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. level updates the cycle after a write or pop.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 while state != IDLE; held at 0 in IDLE.
  - tick = (cnt == TICK_DIV-1).
- FSM states: IDLE, MARK, GAP, LGAP.
  - IDLE: z=0. If empty=0: pop the head and load pattern/length. Load rem = 3 if the first symbol is a dash, else 1. Go to MARK (z=1 from the next cycle).
  - MARK: z=1. On tick:
    - rem>1: decrement rem.
    - rem==1 and more symbols remain: shift the pattern, set rem=1, go to GAP.
    - rem==1 on the last symbol: set rem=3, go to LGAP.
  - GAP: z=0. On tick, load rem from the next symbol (3 for dash, 1 for dot) and go to MARK.
  - LGAP: z=0. On tick with rem>1, decrement rem.
  - LGAP exit (tick with rem==1): letter_done=1 that cycle. If FIFO is non-empty, pop, load and go to MARK; else go to IDLE.
- Resulting timing:
  - Each mark lasts exactly 1×TICK_DIV or 3×TICK_DIV cycles; each gap is exactly 1× or 3×TICK_DIV cycles.
  - Between consecutive queued letters z is low for exactly 3×TICK_DIV cycles.
- abort:
  - Has priority over everything except reset.
  - Next cycle: FIFO emptied, state=IDLE, z=0, cnt=0, no letter_done.
  - A write in the same cycle is dropped silently, with no overflow pulse.
- Outputs z, busy and letter_done are registered or decoded from state only, with no combinational path from inputs.

Test Plan (TICK_DIV=4, FIFO_DEPTH=8):
- Reset, then write T at cycle N:
  - z=1 for cycles N+2..N+13, z=0 for N+14..N+25.
  - letter_done=1 at N+25; busy=0 from N+26.
- Write S: z pattern is 4 high, 4 low, 4 high, 4 low, 4 high, then 12 low. letter_done fires once.
- Write Q, then R on the next cycle:
  - Q plays as 12H 4L 12H 4L 4H 4L 12H, then exactly 12 low.
  - R's first mark starts immediately after; busy stays 1 throughout.
- While the first letter plays, write 9 more letters (8 queued plus one extra):
  - full=1 and level=8.
  - The extra write is dropped with overflow=1 for one cycle.
  - After drain, exactly 9 letter_done pulses total.
- Abort mid-dash of W with 3 letters queued: next cycle z=0, busy=0, empty=1, level=0; no further letter_done.
- Assert Resetn=0 asynchronously mid-MARK of X:
  - z=0 immediately, without waiting for a clock edge; FIFO empty.
  - After release, a fresh write of U plays correctly from the start.
